id_issue_buffer: RTL and testbench



---
 rtl/id_issue_buffer.sv | 109 ++++++++++
 tb/tb_id_issue_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/id_issue_buffer.sv
// Multi-lane circular buffer between instruction decode and issue.
// Accepts up to EnqWidth entries per cycle and presents the DeqWidth oldest to issue.
module id_issue_buffer #(
    parameter int EntryWidth    = 64,
    parameter int Depth         = 4,
    parameter int EnqWidth      = 2,
    parameter int DeqWidth      = 2,
    parameter int CtrlFlowAlone = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                stall_i,
    input  logic [EnqWidth-1:0]                 in_valid_i,
    input  logic [EnqWidth-1:0][EntryWidth-1:0] in_data_i,
    input  logic [EnqWidth-1:0]                 in_ctrl_flow_i,
    output logic [EnqWidth-1:0]                 in_ready_o,
    output logic [DeqWidth-1:0]                 out_valid_o,
    output logic [DeqWidth-1:0][EntryWidth-1:0] out_data_o,
    output logic [DeqWidth-1:0]                 out_ctrl_flow_o,
    input  logic [DeqWidth-1:0]                 out_ack_i,
    output logic [$clog2(Depth):0]              count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        logic [EntryWidth-1:0] data;
        logic                  ctrl_flow;
    } entry_t;

    entry_t          r_storage [Depth];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    logic [EnqWidth-1:0] w_enq;
    logic                w_blocked;
    int                  w_n_deq;
    int                  w_n_enq;
    int                  w_free_eff;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_blocked       = 1'b0;
        out_valid_o     = '0;
        out_data_o      = '0;
        out_ctrl_flow_o = '0;
        for (int j = 0; j < DeqWidth; j++) begin
            out_data_o[j]      = r_storage[r_rd_ptr + PtrW'(j)].data;
            out_ctrl_flow_o[j] = r_storage[r_rd_ptr + PtrW'(j)].ctrl_flow;
            out_valid_o[j]     = (CntW'(j) < r_count) && !((CtrlFlowAlone != 0) && w_blocked);
            w_blocked          = w_blocked | out_ctrl_flow_o[j];
        end
    end

    // Acks free space in the same cycle, so a full buffer can still accept.
    always_comb begin
        w_n_deq = 0;
        w_n_enq = 0;
        for (int j = 0; j < DeqWidth; j++) begin
            w_n_deq = w_n_deq + int'(out_ack_i[j] && !flush_i);
        end
        w_free_eff = Depth - int'(r_count) + w_n_deq;
        for (int k = 0; k < EnqWidth; k++) begin
            in_ready_o[k] = rst_ni && in_valid_i[k] && !stall_i && !flush_i && (k < w_free_eff);
            w_enq[k]      = in_valid_i[k] && in_ready_o[k];
            w_n_enq       = w_n_enq + int'(w_enq[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // NOTE: storage is small and must read back as zero after reset, so it is reset too.
            for (int i = 0; i < Depth; i++) begin
                r_storage[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int k = 0; k < EnqWidth; k++) begin
                if (w_enq[k]) begin
                    r_storage[r_wr_ptr + PtrW'(k)] <= '{data: in_data_i[k], ctrl_flow: in_ctrl_flow_i[k]};
                end
            end
            r_rd_ptr <= r_rd_ptr + PtrW'(w_n_deq);
            r_wr_ptr <= r_wr_ptr + PtrW'(w_n_enq);
            r_count  <= CntW'(int'(r_count) + w_n_enq - w_n_deq);
        end
    end

    assign count_o = r_count;

    a_in_valid_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_valid_i & (in_valid_i + EnqWidth'(1))) == '0);
    a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (out_ack_i & (out_ack_i + DeqWidth'(1))) == '0);
    a_ack_valid: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (out_ack_i & ~out_valid_o) == '0);
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (int'(r_count) + w_n_enq - w_n_deq <= Depth) && (int'(r_count) + w_n_enq - w_n_deq >= 0));

endmodule

// File: tb/tb_id_issue_buffer.sv
// Self-checking bench for id_issue_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_id_issue_buffer;

    localparam int EW = 64;
    localparam int D  = 4;
    localparam int EQ = 2;
    localparam int DQ = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   flush_i = 1'b0;
    logic                   stall_i = 1'b0;
    logic [EQ-1:0]          in_valid_i = '0;
    logic [EQ-1:0][EW-1:0]  in_data_i = '0;
    logic [EQ-1:0]          in_ctrl_flow_i = '0;
    logic [EQ-1:0]          in_ready_o;
    logic [DQ-1:0]          out_valid_o;
    logic [DQ-1:0][EW-1:0]  out_data_o;
    logic [DQ-1:0]          out_ctrl_flow_o;
    logic [DQ-1:0]          out_ack_i = '0;
    logic [$clog2(D):0]     count_o;

    id_issue_buffer #(
        .EntryWidth(EW), .Depth(D), .EnqWidth(EQ), .DeqWidth(DQ), .CtrlFlowAlone(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ctrl_flow_i(in_ctrl_flow_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ctrl_flow_o(out_ctrl_flow_o), .out_ack_i(out_ack_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [EW-1:0] data;
        logic          cf;
    } ent_t;

    ent_t model_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Visible entries: oldest DQ, cut just after the first control-flow entry.
    function automatic int exp_nvis();
        int n;
        n = (model_q.size() < DQ) ? model_q.size() : DQ;
        for (int i = 0; i < n; i++) begin
            if (model_q[i].cf) return i + 1;
        end
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        int nv;
        nv = exp_nvis();
        check({tag, ".count"}, 64'(count_o), 64'(model_q.size()));
        check({tag, ".valid"}, 64'(out_valid_o), 64'((1 << nv) - 1));
        for (int j = 0; j < nv; j++) begin
            check({tag, ".data"}, out_data_o[j], model_q[j].data);
            check({tag, ".cf"}, 64'(out_ctrl_flow_o[j]), 64'(model_q[j].cf));
        end
    endtask

    // One cycle: check state outputs, drive inputs, check ready, clock, update model.
    task automatic step(input string tag, input bit fl, input bit st, input int nval,
                        input int nack, input logic [EQ-1:0] cf);
        int   nfree;
        int   nacc;
        ent_t lane [EQ];
        check_outputs(tag);
        flush_i    = fl;
        stall_i    = st;
        in_valid_i = EQ'((1 << nval) - 1);
        for (int k = 0; k < EQ; k++) begin
            lane[k].data = {$urandom, $urandom};
            lane[k].cf   = cf[k] & in_valid_i[k];
            in_data_i[k]      = lane[k].data;
            in_ctrl_flow_i[k] = lane[k].cf;
        end
        out_ack_i = DQ'((1 << nack) - 1);
        #1;
        nfree = D - model_q.size() + (fl ? 0 : nack);
        nacc  = (fl || st) ? 0 : ((nval < nfree) ? nval : nfree);
        check({tag, ".ready"}, 64'(in_ready_o), 64'((1 << nacc) - 1));
        @(posedge clk_i);
        if (fl) begin
            model_q.delete();
        end else begin
            repeat (nack) void'(model_q.pop_front());
            for (int k = 0; k < nacc; k++) model_q.push_back(lane[k]);
        end
        @(negedge clk_i);
        in_valid_i = '0;
        out_ack_i  = '0;
        flush_i    = 1'b0;
        stall_i    = 1'b0;
    endtask

    initial begin
        in_valid_i = 2'b11;
        #12;
        check("rst.ready", 64'(in_ready_o), 64'd0);
        check("rst.valid", 64'(out_valid_o), 64'd0);
        check("rst.count", 64'(count_o), 64'd0);
        check("rst.data0", out_data_o[0], 64'd0);
        @(negedge clk_i);
        rst_ni     = 1'b1;
        in_valid_i = '0;
        repeat (3) step("idle", 0, 0, 0, 0, 2'b00);

        step("enq_ab", 0, 0, 2, 0, 2'b00);
        step("ack_ab", 0, 0, 0, 2, 2'b00);
        step("empty",  0, 0, 0, 0, 2'b00);

        step("fill1", 0, 0, 2, 0, 2'b00);
        step("fill2", 0, 0, 2, 0, 2'b00);
        step("full_noack", 0, 0, 2, 0, 2'b00);
        step("full_ack1", 0, 0, 1, 1, 2'b00);
        step("drain1", 0, 0, 0, 2, 2'b00);
        step("drain2", 0, 0, 0, 2, 2'b00);

        step("cf_enq", 0, 0, 2, 0, 2'b01);
        step("cf_ack_a", 0, 0, 0, 1, 2'b00);
        step("cf_ack_b", 0, 0, 0, 1, 2'b00);

        step("fl_pre1", 0, 0, 2, 0, 2'b00);
        step("fl_pre2", 0, 0, 1, 0, 2'b00);
        step("flush", 1, 0, 2, 1, 2'b00);
        step("post_flush", 0, 0, 0, 0, 2'b00);

        step("st_pre", 0, 0, 1, 0, 2'b00);
        step("stall", 0, 1, 2, 1, 2'b00);
        step("unstall", 0, 0, 2, 0, 2'b00);
        step("post_stall", 0, 0, 0, 2, 2'b00);

        for (int c = 0; c < 2000; c++) begin
            int nack;
            nack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, exp_nvis())) : 0;
            step("rand", ($urandom_range(0, 24) == 0), ($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, EQ)), nack,
                 EQ'(($urandom_range(0, 3) == 0) ? $urandom : 0));
        end

        while (model_q.size() == 0) step("refill", 0, 0, 2, 0, 2'b00);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst.count", 64'(count_o), 64'd0);
        check("midrst.valid", 64'(out_valid_o), 64'd0);
        model_q.delete();
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        step("after_rst", 0, 0, 2, 0, 2'b00);
        step("after_rst2", 0, 0, 0, 0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
